// File: rtl/seq_arb_wrr_param.sv
// rtl/seq_arb_wrr_param.sv - weighted round-robin arbiter with per-requester burst weights
module seq_arb_wrr_param #(
  parameter int NREQS = 4,
  parameter int WBITS = 3,
  localparam int IW = (NREQS > 1) ? $clog2(NREQS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQS-1:0]       reqs,
  input  logic [NREQS*WBITS-1:0] weights,
  input  logic                   ready,
  output logic [NREQS-1:0]       grants,
  output logic [IW-1:0]          grant_idx,
  output logic                   grant_val
);

  // prio marks the requester scanned first; cnt counts transfers already given to it in its burst
  logic [NREQS-1:0] prio;
  logic [WBITS-1:0] cnt;

  logic [IW-1:0]    p_idx;
  logic [IW-1:0]    next_idx;
  logic [WBITS-1:0] w_raw;
  logic [WBITS:0]   w_eff;
  logic [WBITS:0]   c_cur;
  logic [WBITS:0]   c_next;
  logic             keep_prio;
  logic             xfer;

  // binary index of the one-hot priority pointer
  always_comb begin
    p_idx = '0;
    for (int i = 0; i < NREQS; i++) begin
      if (prio[i]) p_idx = IW'(i);
    end
  end

  // circular scan starting at the priority position; first active request wins
  always_comb begin
    int j;
    grants    = '0;
    grant_idx = '0;
    grant_val = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQS; k++) begin
      j = (int'(p_idx) + k) % NREQS;
      if (!grant_val && reqs[j]) begin
        grants[j] = 1'b1;
        grant_idx = IW'(j);
        grant_val = 1'b1;
      end
    end
  end

  // burst accounting for the granted requester; extra bit keeps c+1 from wrapping
  always_comb begin
    w_raw     = weights[int'(grant_idx)*WBITS +: WBITS];
    w_eff     = (w_raw == '0) ? (WBITS+1)'(1) : {1'b0, w_raw};
    c_cur     = (grant_idx == p_idx) ? {1'b0, cnt} : '0;
    c_next    = c_cur + (WBITS+1)'(1);
    keep_prio = (c_next < w_eff);
    next_idx  = (grant_idx == IW'(NREQS-1)) ? '0 : grant_idx + IW'(1);
    xfer      = grant_val & ready;
  end

  // priority/count update on each accepted grant; reset wins over any transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= {{(NREQS-1){1'b0}}, 1'b1};
      cnt  <= '0;
    end else if (xfer) begin
      if (keep_prio) begin
        prio <= {{(NREQS-1){1'b0}}, 1'b1} << grant_idx;
        cnt  <= c_next[WBITS-1:0];
      end else begin
        prio <= {{(NREQS-1){1'b0}}, 1'b1} << next_idx;
        cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_arb_wrr_param.sv
// tb/tb_seq_arb_wrr_param.sv - scoreboard bench for the weighted round-robin arbiter
module tb_seq_arb_wrr_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  reqs = '0;
  logic [11:0] weights = '0;
  logic        ready = 1'b0;
  logic [3:0]  grants;
  logic [1:0]  grant_idx;
  logic        grant_val;

  logic        reset3 = 1'b1;
  logic [2:0]  reqs3 = '0;
  logic [8:0]  weights3 = '0;
  logic        ready3 = 1'b0;
  logic [2:0]  grants3;
  logic [1:0]  grant_idx3;
  logic        grant_val3;

  seq_arb_wrr_param #(.NREQS(4), .WBITS(3)) dut (
    .clk(clk), .reset(reset), .reqs(reqs), .weights(weights), .ready(ready),
    .grants(grants), .grant_idx(grant_idx), .grant_val(grant_val)
  );

  seq_arb_wrr_param #(.NREQS(3), .WBITS(3)) dut3 (
    .clk(clk), .reset(reset3), .reqs(reqs3), .weights(weights3), .ready(ready3),
    .grants(grants3), .grant_idx(grant_idx3), .grant_val(grant_val3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sel;
    logic [3:0] g;
    logic [15:0] n;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   step_no = 0;

  localparam logic [11:0] W_ALL1 = {3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [11:0] W_W0_3 = {3'd1, 3'd1, 3'd1, 3'd3};
  localparam logic [11:0] W_W3_2 = {3'd2, 3'd1, 3'd1, 3'd1};

  function automatic logic [1:0] onehot_idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string name, input int n, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
  endtask

  // monitor: every cycle with a pending expectation, compare the selected DUT's outputs
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] ag;
      logic [1:0] ai;
      logic       av;
      e  = sb.pop_front();
      ag = e.sel ? {1'b0, grants3} : grants;
      ai = e.sel ? grant_idx3 : grant_idx;
      av = e.sel ? grant_val3 : grant_val;
      check("grants",    int'(e.n), int'(ag), int'(e.g));
      check("grant_idx", int'(e.n), int'(ai), int'(onehot_idx(e.g)));
      check("grant_val", int'(e.n), int'(av), int'(|e.g));
    end
  end

  task automatic step4(input logic rst, input logic [3:0] rq, input logic rdy,
                       input logic [11:0] w, input logic [3:0] exp, input logic chk);
    @(posedge clk);
    #1;
    reset = rst; reqs = rq; ready = rdy; weights = w;
    step_no++;
    if (chk) sb.push_back('{1'b0, exp, 16'(step_no)});
  endtask

  task automatic step3(input logic rst, input logic [2:0] rq, input logic [2:0] exp);
    @(posedge clk);
    #1;
    reset3 = rst; reqs3 = rq; ready3 = 1'b1; weights3 = '0;
    step_no++;
    sb.push_back('{1'b1, {1'b0, exp}, 16'(step_no)});
  endtask

  task automatic do_reset();
    step4(1'b1, 4'b0000, 1'b0, W_ALL1, 4'b0000, 1'b1);
  endtask

  initial begin
    step4(1'b1, 4'b0000, 1'b0, W_ALL1, 4'b0000, 1'b0);
    do_reset();

    // plain round-robin with unit weights
    step4(0, 4'b1111, 1, W_ALL1, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_ALL1, 4'b0010, 1);
    step4(0, 4'b1111, 1, W_ALL1, 4'b0100, 1);
    step4(0, 4'b1111, 1, W_ALL1, 4'b1000, 1);
    step4(0, 4'b1111, 1, W_ALL1, 4'b0001, 1);
    do_reset();

    // requester 0 bursts three transfers
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0010, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0100, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b1000, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    do_reset();

    // back-pressure holds state
    step4(0, 4'b0110, 0, W_ALL1, 4'b0010, 1);
    step4(0, 4'b0110, 0, W_ALL1, 4'b0010, 1);
    step4(0, 4'b0110, 0, W_ALL1, 4'b0010, 1);
    step4(0, 4'b0110, 1, W_ALL1, 4'b0010, 1);
    step4(0, 4'b0110, 1, W_ALL1, 4'b0100, 1);
    do_reset();

    // dropped request forfeits the burst
    step4(0, 4'b0001, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1010, 1, W_W0_3, 4'b0010, 1);
    step4(0, 4'b1010, 1, W_W0_3, 4'b1000, 1);
    step4(0, 4'b1010, 1, W_W0_3, 4'b0010, 1);
    do_reset();

    // idle cycles keep the burst count
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b0000, 1, W_W0_3, 4'b0000, 1);
    step4(0, 4'b0000, 1, W_W0_3, 4'b0000, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0010, 1);
    do_reset();

    // reset mid-burst restarts the count
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(1, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_W0_3, 4'b0010, 1);
    do_reset();

    // weight lowered mid-burst rotates on the next transfer
    step4(0, 4'b1111, 1, W_W0_3, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_ALL1, 4'b0001, 1);
    step4(0, 4'b1111, 1, W_ALL1, 4'b0010, 1);
    do_reset();

    // top requester exhausts its burst and wraps priority to bit 0
    step4(0, 4'b1000, 1, W_W3_2, 4'b1000, 1);
    step4(0, 4'b1000, 1, W_W3_2, 4'b1000, 1);
    step4(0, 4'b1001, 1, W_W3_2, 4'b0001, 1);
    step4(0, 4'b1001, 1, W_W3_2, 4'b1000, 1);

    // three requesters, zero weights behave as one
    step3(1'b1, 3'b000, 3'b000);
    step3(1'b0, 3'b111, 3'b001);
    step3(1'b0, 3'b111, 3'b010);
    step3(1'b0, 3'b111, 3'b100);
    step3(1'b0, 3'b111, 3'b001);

    repeat (4) @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_arb_wrr_param.md
SEQ_ARB_WRR_PARAM -- requirements
Module: seq_arb_wrr_param

Interface
REQ-001: NREQS, default 4, number of requesters; legal range 2..16.
REQ-002: WBITS, default 3, width of each per-requester weight field; legal range 1..8.
REQ-003: clk  input  1  clock; all state updates on the rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: reqs  input  NREQS  request vector; bit i is requester i.
REQ-006: weights  input  NREQS*WBITS  per-requester burst weight; field i occupies bits [i*WBITS +: WBITS].
REQ-007: ready  input  1  downstream accepts the current grant this cycle (transfer = grant_val & ready).
REQ-008: grants  output  NREQS  one-hot grant vector, or all zero when there is no grant.
REQ-009: grant_idx  output  clog2(NREQS)  binary index of the granted requester; 0 when grant_val=0.
REQ-010: grant_val  output  1  high iff grants is nonzero.

Function
REQ-011: State SHALL be prio (one-hot, NREQS bits) and cnt (WBITS bits); there is no other state.
REQ-012: grants SHALL be combinational from prio and reqs: scan from the prio position upward with wrap-around (p, p+1, ..., NREQS-1, 0, ..., p-1); the first set reqs bit is granted.
REQ-013: reqs=0 SHALL give grants=0, grant_val=0 and grant_idx=0.
REQ-014: Effective weight w(i) SHALL be weights field i, with 0 treated as 1.
REQ-015: On a transfer to index g, with p = the prio index: c = (g==p) ? cnt : 0, evaluated with WBITS+1 bit arithmetic (no overflow).
REQ-016: If c+1 < w(g): prio <= onehot(g), cnt <= c+1, so g keeps top priority for its next request.
REQ-017: Otherwise: prio <= onehot((g+1) mod NREQS), cnt <= 0.
REQ-018: With no transfer (grant_val=0 or ready=0), prio and cnt SHALL hold; grants may change if reqs changes.
REQ-019: Weights SHALL be sampled every cycle. A weight lowered mid-burst to <= cnt rotates priority on the next transfer.
REQ-020: With all weights <= 1, behaviour SHALL equal classic one-hot round-robin: priority moves to the granted index + 1 after every transfer.
REQ-021: A requester that drops reqs mid-burst forfeits the remainder of its burst. The next transfer to another index g' uses c=0 and starts g' counting per REQ-016/017.
REQ-022: Wrap-around: a transfer to index NREQS-1 that exhausts its weight SHALL set prio to bit 0.
REQ-023: Grants SHALL depend only on current reqs and state; there is no latency from a reqs change to grants.

Reset
REQ-024: While reset is high at a rising edge: prio <= onehot(0) and cnt <= 0, overriding any transfer in that cycle.
REQ-025: Outputs during and after reset SHALL follow REQ-012/013 from prio=onehot(0). With reqs=0, grants=0, grant_val=0 and grant_idx=0.
REQ-026: Reset asserted mid-burst SHALL discard the burst; the first post-reset grant is the lowest-indexed active requester.

Verification (NREQS=4, WBITS=3 unless stated)
REQ-027: Weights all 1, reqs=1111, ready=1 from reset -> grants 0001, 0010, 0100, 1000, 0001 on successive cycles.
REQ-028: w0=3, others 1, reqs=1111, ready=1 -> grants 0001, 0001, 0001, 0010, 0100, 1000, 0001.
REQ-029: Weights 1, reqs=0110, ready=0 for 3 cycles -> grants stay 0010 with grant_idx=1. Then ready=1 -> 0010, then 0100.
REQ-030: w0=3; reqs=0001 for one transfer, then reqs=1010 -> grants 0010, then 1000, then 0010 (burst forfeited).
REQ-031: reqs=0000 -> grants=0000, grant_val=0, and state is unchanged. Reset asserted after the 2nd grant of REQ-028 -> the next grant is 0001 with cnt restarting from 0.
REQ-032: NREQS=3, all weights 0, reqs=111 -> grants 001, 010, 100, 001, covering the weight-0 case and wrap-around.
